// File: rtl/z_test_ctrl.sv
// Depth-test sequencer for one 32x32 tile: read stored Z, compare, write back, with
// write forwarding for close same-address pixels and a full-tile Z clear sequencer.
//
// state | meaning
// IDLE  | pixels flow; waiting for clear_start
// DRAIN | clear requested; letting in-flight pixels and their writes finish
// CLEAR | writing clear_z to every tile entry, one per cycle
module z_test_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear_start,
    input  logic [31:0] clear_z,
    output logic        clear_busy,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_x,
    input  logic [4:0]  in_y,
    input  logic [31:0] in_z,
    input  logic [2:0]  in_depth_comp,
    input  logic        in_zwrite_dis,
    output logic        out_valid,
    output logic [4:0]  out_x,
    output logic [4:0]  out_y,
    output logic        out_pass,
    output logic [9:0]  zram_addr,
    output logic        zram_rd,
    input  logic [31:0] zram_rdata,
    output logic        zram_wr,
    output logic [31:0] zram_wdata
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [9:0]  clr_cnt;
    logic [31:0] clr_z_q;

    logic        accept;
    logic        pipe_busy;
    logic        enter_clear;

    // stage A: registered request, read issued this cycle
    logic        a_valid;
    logic [4:0]  a_x, a_y;
    logic [31:0] a_z;
    logic [2:0]  a_mode;
    logic        a_zdis;

    // stage B: read data returns this cycle
    logic        b_valid;
    logic [4:0]  b_x, b_y;
    logic [31:0] b_z;
    logic [2:0]  b_mode;
    logic        b_zdis;
    logic [9:0]  b_addr;

    // write currently driven, and the one driven the cycle before
    logic        wr_valid;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr2_valid;
    logic [9:0]  wr2_addr;
    logic [31:0] wr2_data;

    logic signed [31:0] ip_z;
    logic signed [31:0] old_z;
    logic               pass;

    assign clear_busy = (state != ST_IDLE);
    assign in_ready   = !clear_busy && !clear_start && !reset;
    assign accept     = in_valid && in_ready;
    assign pipe_busy  = a_valid || b_valid || wr_valid;
    assign b_addr     = {b_y, b_x};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        enter_clear = 1'b0;
        case (state)
            ST_IDLE: begin
                if (clear_start) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!pipe_busy) begin
                    state_next  = ST_CLEAR;
                    enter_clear = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt == 10'd1023) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clr_cnt <= '0;
            clr_z_q <= '0;
        end else begin
            if (state == ST_IDLE && clear_start) begin
                clr_z_q <= clear_z;
            end
            if (state == ST_CLEAR) begin
                clr_cnt <= clr_cnt + 10'd1;
            end else begin
                clr_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_valid <= 1'b0;
            a_x     <= '0;
            a_y     <= '0;
            a_z     <= '0;
            a_mode  <= '0;
            a_zdis  <= 1'b0;
            b_valid <= 1'b0;
            b_x     <= '0;
            b_y     <= '0;
            b_z     <= '0;
            b_mode  <= '0;
            b_zdis  <= 1'b0;
        end else begin
            a_valid <= accept;
            if (accept) begin
                a_x    <= in_x;
                a_y    <= in_y;
                a_z    <= in_z;
                a_mode <= in_depth_comp;
                a_zdis <= in_zwrite_dis;
            end
            b_valid <= a_valid;
            b_x     <= a_x;
            b_y     <= a_y;
            b_z     <= a_z;
            b_mode  <= a_mode;
            b_zdis  <= a_zdis;
        end
    end

    // The SRAM returns old data when read and written in the same cycle, so the two
    // most recent writes must override it; the newer one wins.
    always_comb begin
        old_z = zram_rdata;
        if (wr_valid && wr_addr == b_addr) begin
            old_z = wr_data;
        end else if (wr2_valid && wr2_addr == b_addr) begin
            old_z = wr2_data;
        end
    end

    assign ip_z = b_z;

    always_comb begin
        pass = 1'b0;
        case (b_mode)
            3'd0: pass = 1'b0;
            3'd1: pass = (ip_z <  old_z);
            3'd2: pass = (ip_z == old_z);
            3'd3: pass = (ip_z <= old_z);
            3'd4: pass = (ip_z >  old_z);
            3'd5: pass = (ip_z != old_z);
            3'd6: pass = (ip_z >= old_z);
            3'd7: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_pass  <= 1'b0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            wr2_valid <= 1'b0;
            wr2_addr  <= '0;
            wr2_data  <= '0;
        end else begin
            out_valid <= b_valid;
            out_x     <= b_x;
            out_y     <= b_y;
            out_pass  <= b_valid && pass;
            wr_valid  <= b_valid && pass && !b_zdis && !enter_clear;
            wr_addr   <= b_addr;
            wr_data   <= b_z;
            wr2_valid <= wr_valid && !enter_clear;
            wr2_addr  <= wr_addr;
            wr2_data  <= wr_data;
        end
    end

    // Externally the read address takes the port whenever a read is pending; the
    // integration takes the write address from the registered write path.
    always_comb begin
        zram_rd    = a_valid;
        zram_wr    = wr_valid || (state == ST_CLEAR);
        zram_wdata = wr_data;
        zram_addr  = wr_addr;
        if (state == ST_CLEAR) begin
            zram_wdata = clr_z_q;
            zram_addr  = clr_cnt;
        end
        if (a_valid) begin
            zram_addr = {a_y, a_x};
        end
    end

endmodule

// File: tb/tb_z_test_ctrl.sv
// Directed bench for z_test_ctrl: vector table for the compare modes plus
// hand sequences for forwarding, write disable, tile clear and reset abort.
module tb_z_test_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        clear_start = 1'b0;
    logic [31:0] clear_z = '0;
    logic        clear_busy;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_x = '0;
    logic [4:0]  in_y = '0;
    logic [31:0] in_z = '0;
    logic [2:0]  in_depth_comp = '0;
    logic        in_zwrite_dis = 1'b0;
    logic        out_valid;
    logic [4:0]  out_x;
    logic [4:0]  out_y;
    logic        out_pass;
    logic [9:0]  zram_addr;
    logic        zram_rd;
    logic [31:0] zram_rdata = '0;
    logic        zram_wr;
    logic [31:0] zram_wdata;

    int passed = 0;
    int total  = 0;

    z_test_ctrl dut (
        .clock(clock), .reset(reset),
        .clear_start(clear_start), .clear_z(clear_z), .clear_busy(clear_busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
        .in_z(in_z), .in_depth_comp(in_depth_comp), .in_zwrite_dis(in_zwrite_dis),
        .out_valid(out_valid), .out_x(out_x), .out_y(out_y), .out_pass(out_pass),
        .zram_addr(zram_addr), .zram_rd(zram_rd), .zram_rdata(zram_rdata),
        .zram_wr(zram_wr), .zram_wdata(zram_wdata)
    );

    always #5 clock = ~clock;

    // Tile SRAM model: read-before-write, write address from the registered write path.
    logic [31:0] mem [1024];
    logic        bd_we = 1'b0;
    logic [9:0]  bd_addr = '0;
    logic [31:0] bd_data = '0;

    always @(posedge clock) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        if (zram_rd) zram_rdata <= mem[zram_addr];
        if (zram_wr) mem[zram_rd ? dut.wr_addr : zram_addr] <= zram_wdata;
    end

    typedef struct packed {
        logic        pass;
        logic        wr;
        logic [31:0] wdata;
    } res_t;
    res_t res_q[$];

    always @(negedge clock) begin
        if (out_valid) res_q.push_back({out_pass, zram_wr, zram_wdata});
    end

    typedef struct {
        logic [4:0]  x;
        logic [4:0]  y;
        logic [31:0] z;
        logic [31:0] stored;
        logic [2:0]  mode;
        logic        zdis;
        logic        pass;
        logic        wr;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic [4:0] x, input logic [4:0] y,
                                input logic [31:0] z, input logic [31:0] stored,
                                input logic [2:0] mode, input logic zdis,
                                input logic pass, input logic wr);
        vec_t v;
        v.x = x; v.y = y; v.z = z; v.stored = stored;
        v.mode = mode; v.zdis = zdis; v.pass = pass; v.wr = wr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        tick();
        bd_we = 1'b0;
    endtask

    task automatic drive(input logic [4:0] x, input logic [4:0] y, input logic [31:0] z,
                         input logic [2:0] mode, input logic zdis);
        in_valid = 1'b1; in_x = x; in_y = y; in_z = z;
        in_depth_comp = mode; in_zwrite_dis = zdis;
    endtask

    task automatic b2b(input int gap, input string tag);
        preload(10'd0, 32'd1000);
        res_q.delete();
        drive(5'd0, 5'd0, 32'd500, 3'd1, 1'b0);
        tick();
        in_valid = 1'b0;
        repeat (gap) tick();
        drive(5'd0, 5'd0, 32'd700, 3'd1, 1'b0);
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
        chk({tag, "_count"}, res_q.size(), 2);
        if (res_q.size() == 2) begin
            chk({tag, "_p1_pass"}, res_q[0].pass, 1);
            chk({tag, "_p1_wr"}, res_q[0].wr, 1);
            chk({tag, "_p1_wdata"}, res_q[0].wdata, 500);
            chk({tag, "_p2_pass"}, res_q[1].pass, 0);
            chk({tag, "_p2_wr"}, res_q[1].wr, 0);
        end
        chk({tag, "_mem0"}, mem[0], 500);
    endtask

    logic [7:0] masks [3];
    logic [31:0] zs [3];

    initial begin
        int idx;
        vec_t v;
        int busy_cnt, wcnt, werr, rdy_err, ov_err;
        logic done, found;

        // expected pass per mode (bit index = mode) against stored -5
        masks[0] = 8'hCC; zs[0] = 32'hFFFF_FFFB;   // in_z = -5
        masks[1] = 8'hAA; zs[1] = 32'hFFFF_FFFA;   // in_z = -6
        masks[2] = 8'hF0; zs[2] = 32'd7;           // in_z =  7

        vecs[0] = mk(5'd3, 5'd5, 32'd200, 32'd100, 3'd4, 1'b0, 1'b1, 1'b1);
        vecs[1] = mk(5'd3, 5'd5, 32'd200, 32'd100, 3'd1, 1'b0, 1'b0, 1'b0);
        for (int zi = 0; zi < 3; zi++) begin
            for (int m = 0; m < 8; m++) begin
                idx = 2 + zi * 8 + m;
                vecs[idx] = mk(5'(idx), 5'(31 - idx), zs[zi], 32'hFFFF_FFFB, 3'(m),
                               1'b0, masks[zi][m], masks[zi][m]);
            end
        end
        vecs[26] = mk(5'd10, 5'd20, 32'hFFFF_FFFD, 32'd0, 3'd1, 1'b1, 1'b1, 1'b0);

        #12;
        chk("reset_outputs", 32'({in_ready, clear_busy, out_valid, out_x, out_y, out_pass,
                                  zram_rd, zram_wr} | 32'(zram_addr) | zram_wdata), 0);
        reset = 1'b0;
        tick();
        chk("reset_in_ready", in_ready, 1);
        chk("reset_clear_busy", clear_busy, 0);

        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            preload({v.y, v.x}, v.stored);
            drive(v.x, v.y, v.z, v.mode, v.zdis);
            tick();
            in_valid = 1'b0;
            chk($sformatf("v%0d_rd", i), zram_rd, 1);
            chk($sformatf("v%0d_rd_addr", i), zram_addr, {v.y, v.x});
            tick();
            chk($sformatf("v%0d_early", i), out_valid, 0);
            tick();
            chk($sformatf("v%0d_valid", i), out_valid, 1);
            chk($sformatf("v%0d_pass", i), out_pass, v.pass);
            chk($sformatf("v%0d_xy", i), {out_y, out_x}, {v.y, v.x});
            chk($sformatf("v%0d_wr", i), zram_wr, v.wr);
            if (v.wr) begin
                chk($sformatf("v%0d_waddr", i), zram_addr, {v.y, v.x});
                chk($sformatf("v%0d_wdata", i), zram_wdata, v.z);
            end
            tick();
            tick();
        end

        b2b(0, "fwd_src1");
        b2b(1, "fwd_src2");
        b2b(2, "sram_path");

        // write disabled pass must not be forwarded to the next pixel
        preload(10'd71, 32'd100);
        res_q.delete();
        drive(5'd7, 5'd2, 32'd50, 3'd1, 1'b1);
        tick();
        drive(5'd7, 5'd2, 32'd80, 3'd1, 1'b0);
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
        chk("zdis_count", res_q.size(), 2);
        if (res_q.size() == 2) begin
            chk("zdis_p1_pass", res_q[0].pass, 1);
            chk("zdis_p1_wr", res_q[0].wr, 0);
            chk("zdis_p2_pass", res_q[1].pass, 1);
            chk("zdis_p2_wdata", res_q[1].wdata, 80);
        end
        chk("zdis_mem", mem[71], 80);

        // full tile clear, with a colliding pixel and an ignored second clear_start
        clear_z = 32'h8000_0000;
        clear_start = 1'b1;
        drive(5'd1, 5'd1, 32'd9, 3'd7, 1'b0);
        #1;
        chk("clear_start_in_ready", in_ready, 0);
        tick();
        clear_start = 1'b0;
        in_valid = 1'b0;
        busy_cnt = 0; wcnt = 0; werr = 0; rdy_err = 0; ov_err = 0; done = 1'b0;
        for (int c = 0; c < 1100; c++) begin
            if (clear_busy) busy_cnt++;
            if (clear_busy && in_ready) rdy_err++;
            if (out_valid) ov_err++;
            if (zram_wr) begin
                if (zram_addr != 10'(wcnt) || zram_wdata != 32'h8000_0000) werr++;
                wcnt++;
            end
            if (!clear_busy) begin
                done = 1'b1;
                break;
            end
            if (c == 100) begin
                clear_start = 1'b1;
                clear_z = 32'h1234_5678;
            end
            tick();
            clear_start = 1'b0;
        end
        chk("clear_done", done, 1);
        chk("clear_busy_len", (busy_cnt >= 1024 && busy_cnt <= 1026), 1);
        chk("clear_writes", wcnt, 1024);
        chk("clear_write_errs", werr, 0);
        chk("clear_ready_errs", rdy_err, 0);
        chk("clear_pixel_blocked", ov_err, 0);
        chk("clear_after_wr", zram_wr, 0);
        chk("clear_after_ready", in_ready, 1);
        chk("clear_mem_first", mem[0], 32'h8000_0000);
        chk("clear_mem_last", mem[1023], 32'h8000_0000);

        // reset in the middle of a clear
        preload(10'd600, 32'd123);
        clear_z = 32'd0;
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 1100; c++) begin
            if (zram_wr && zram_addr == 10'd500) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("abort_reach_500", found, 1);
        #2 reset = 1'b1;
        #1;
        chk("abort_outputs", 32'({in_ready, clear_busy, out_valid, out_x, out_y, out_pass,
                                  zram_rd, zram_wr} | 32'(zram_addr) | zram_wdata), 0);
        #2 reset = 1'b0;
        tick();
        chk("abort_in_ready", in_ready, 1);
        chk("abort_clear_busy", clear_busy, 0);
        chk("abort_mem499", mem[499], 0);
        chk("abort_mem500", mem[500], 32'h8000_0000);
        chk("abort_mem600", mem[600], 123);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
